pc_redirect_unit: RTL

//  Owns the fetch PC and consumes the 2-bit br_taken verdict computed in EX by the branch comparator.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/pc_reg.sv | 32 +++
 rtl/pc_redirect_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module : pipeline_pkg
// Brief  : Branch verdict encodings and redirect FSM state type shared by
//          the branch comparator and the PC redirect unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam logic [1:0]  BR_NONE = 2'b00;
  localparam logic [1:0]  BR_COND = 2'b01;
  localparam logic [1:0]  BR_JUMP = 2'b10;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } redir_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module : pc_reg
// Brief  : 32-bit fetch PC register with synchronous reset and load enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= d;
    end
  end

  assign q = r_pc;

endmodule

`default_nettype wire

// File: rtl/pc_redirect_unit.sv
// ============================================================================
// Module : pc_redirect_unit
// Brief  : Next-PC selection, wrong-path squash with post-redirect shadow
//          window, and branch/taken performance counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          SHADOW_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        br_valid,
  input  logic [1:0]  br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        redirect,
  output logic        target_misalign,
  output logic [31:0] branch_cnt,
  output logic [31:0] taken_cnt
);

  localparam int            CW            = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES) : 1;
  localparam logic [CW-1:0] C_SHADOW_LOAD = CW'(SHADOW_CYCLES - 1);

  redir_state_t  r_state, w_state_next;
  logic [CW-1:0] r_shadow_cnt, w_shadow_cnt_next;
  logic [31:0]   r_branch_cnt, r_taken_cnt;
  logic [31:0]   w_pc_next;
  logic          w_take, w_load, w_count_branch;
  logic          w_unused_target_bit0;

  assign w_unused_target_bit0 = br_target[0];

  always_comb begin
    w_state_next      = r_state;
    w_shadow_cnt_next = r_shadow_cnt;
    w_take            = 1'b0;
    w_count_branch    = 1'b0;
    case (r_state)
      RUN: begin
        w_count_branch = br_valid;
        w_take = br_valid & ((br_taken == BR_COND) | (br_taken == BR_JUMP));
        if (w_take) begin
          w_state_next      = SHADOW;
          w_shadow_cnt_next = C_SHADOW_LOAD;
        end
      end
      SHADOW: begin
        // Exit after the cycle in which the counter reads zero.
        if (r_shadow_cnt == '0) begin
          w_state_next = RUN;
        end else begin
          w_shadow_cnt_next = r_shadow_cnt - 1'b1;
        end
      end
      default: w_state_next = RUN;
    endcase
    if (rst) begin
      w_take         = 1'b0;
      w_count_branch = 1'b0;
    end
    redirect        = w_take;
    flush_ifid      = w_take;
    flush_idex      = w_take;
    target_misalign = w_take & br_target[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_shadow_cnt <= '0;
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_shadow_cnt <= w_shadow_cnt_next;
      if (w_count_branch) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_take)         r_taken_cnt  <= r_taken_cnt + 32'd1;
    end
  end

  // Redirect wins over stall; bit 0 of the target is always cleared.
  assign w_pc_next = w_take ? {br_target[31:1], 1'b0} : pc_plus4;
  assign w_load    = w_take | ~stall_if;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .d    (w_pc_next),
    .q    (pc_out)
  );

  assign pc_plus4   = pc_out + PC_INC;
  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;

endmodule

`default_nettype wire
